// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw, asynchronous, possibly bouncing push-button level into a clean
// debounced level. The raw input passes through a two-flop synchronizer. A new
// level is accepted only after it has been sampled for STABLE_CYCLES
// consecutive cycles.
//
// Parameters
//   STABLE_CYCLES : consecutive synchronized samples a new level must hold
//                   before `pressed` follows it (>= 1)
//
// Ports
//   clk     in  : system clock, rising-edge active
//   reset   in  : asynchronous active-high reset, clears all state
//   key     in  : raw button level (1 = depressed), asynchronous to clk
//   pressed out : debounced level, registered (1 = button held)
//   busy    out : registered, 1 while a candidate level change is being
//                 qualified (counter nonzero)
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pressed,
    output logic busy
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    // Count value at which the next mismatching sample completes qualification.
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_pressed;
    logic          r_busy;

    assign pressed = r_pressed;
    assign busy    = r_busy;

    // Single state machine. `pressed` and `busy` are registered alongside the
    // state so that they change exactly on the edge that changes the state or
    // the counter, with no combinational decode on the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= ST_RELEASED;
            r_cnt     <= CNT_ZERO;
            r_pressed <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Two-flop synchronizer; only r_sync2 feeds the decision logic.
            r_sync1 <= key;
            r_sync2 <= r_sync1;

            case (r_state)
                ST_RELEASED: begin
                    r_pressed <= 1'b0;
                    if (r_sync2) begin
                        // A one-cycle qualification window means the first
                        // mismatching sample is already enough.
                        if (STABLE_CYCLES == 1) begin
                            r_state   <= ST_PRESSED;
                            r_pressed <= 1'b1;
                            r_cnt     <= CNT_ZERO;
                            r_busy    <= 1'b0;
                        end else begin
                            r_state <= ST_PRESS_WAIT;
                            r_cnt   <= CNT_ONE;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_cnt  <= CNT_ZERO;
                        r_busy <= 1'b0;
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!r_sync2) begin
                        // Sample matches the current level: abort, drop count.
                        r_state <= ST_RELEASED;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_PRESSED;
                        r_pressed <= 1'b1;
                        r_cnt     <= CNT_ZERO;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_PRESSED: begin
                    r_pressed <= 1'b1;
                    if (!r_sync2) begin
                        if (STABLE_CYCLES == 1) begin
                            r_state   <= ST_RELEASED;
                            r_pressed <= 1'b0;
                            r_cnt     <= CNT_ZERO;
                            r_busy    <= 1'b0;
                        end else begin
                            r_state <= ST_RELEASE_WAIT;
                            r_cnt   <= CNT_ONE;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_cnt  <= CNT_ZERO;
                        r_busy <= 1'b0;
                    end
                end

                ST_RELEASE_WAIT: begin
                    if (r_sync2) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_RELEASED;
                        r_pressed <= 1'b0;
                        r_cnt     <= CNT_ZERO;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state   <= ST_RELEASED;
                    r_pressed <= 1'b0;
                    r_cnt     <= CNT_ZERO;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed testbench for button_debouncer with STABLE_CYCLES = 4. Each task
// drives one scenario and compares `pressed` / `busy` against hand-computed
// per-edge expectations. Inputs change 1 ns after a rising edge, outputs are
// sampled at the same point (after the edge has settled).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_debouncer;

    logic clk;
    logic reset;
    logic key;
    logic pressed;
    logic busy;

    int vectors;
    int errors;

    button_debouncer #(.STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .key     (key),
        .pressed (pressed),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and let it settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key   = 1'b1;
        #1;
        vectors++;
        if (pressed !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: pressed=%b busy=%b, expected pressed=0 busy=0", pressed, busy);
        end
        $display("reset_async: pressed=%b busy=%b", pressed, busy);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (pressed !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: pressed=%b busy=%b, expected pressed=0 busy=0", i, pressed, busy);
            end
            $display("reset_hold[%0d]: pressed=%b busy=%b", i, pressed, busy);
        end
        key   = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    // Key 0->1 applied before edge 0; busy after edges 2..4, pressed after 5.
    task automatic test_clean_press();
        bit exp_p[6] = '{0, 0, 0, 0, 0, 1};
        bit exp_b[6] = '{0, 0, 1, 1, 1, 0};
        key = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (pressed !== exp_p[i] || busy !== exp_b[i]) begin
                errors++;
                $display("FAIL clean_press[%0d]: pressed=%b busy=%b, expected pressed=%b busy=%b",
                         i, pressed, busy, exp_p[i], exp_b[i]);
            end
            $display("clean_press[%0d]: key=%b pressed=%b busy=%b", i, key, pressed, busy);
        end
    endtask

    // Key held at 1 for a while: pressed must stay, busy stays low.
    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (pressed !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: pressed=%b busy=%b, expected pressed=1 busy=0", i, pressed, busy);
            end
            $display("hold[%0d]: pressed=%b busy=%b", i, pressed, busy);
        end
    endtask

    // Short 3-cycle drop while pressed: qualification starts and aborts.
    task automatic test_glitch_held();
        bit k_seq[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        bit exp_b[8] = '{0, 0, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            key = k_seq[i];
            tick();
            vectors++;
            if (pressed !== 1'b1 || busy !== exp_b[i]) begin
                errors++;
                $display("FAIL glitch_held[%0d]: pressed=%b busy=%b, expected pressed=1 busy=%b",
                         i, pressed, busy, exp_b[i]);
            end
            $display("glitch_held[%0d]: key=%b pressed=%b busy=%b", i, key, pressed, busy);
        end
    endtask

    task automatic test_clean_release();
        bit exp_p[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        bit exp_b[8] = '{0, 0, 1, 1, 1, 0, 0, 0};
        key = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (pressed !== exp_p[i] || busy !== exp_b[i]) begin
                errors++;
                $display("FAIL clean_release[%0d]: pressed=%b busy=%b, expected pressed=%b busy=%b",
                         i, pressed, busy, exp_p[i], exp_b[i]);
            end
            $display("clean_release[%0d]: key=%b pressed=%b busy=%b", i, key, pressed, busy);
        end
    endtask

    // 1,0,1,0 bounce, then held 1 from edge 4: pressed after edge 9 only.
    task automatic test_bounce();
        bit k_seq[11] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
        bit exp_p[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        bit exp_b[11] = '{0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0};
        for (int i = 0; i < 11; i++) begin
            key = k_seq[i];
            tick();
            vectors++;
            if (pressed !== exp_p[i] || busy !== exp_b[i]) begin
                errors++;
                $display("FAIL bounce[%0d]: pressed=%b busy=%b, expected pressed=%b busy=%b",
                         i, pressed, busy, exp_p[i], exp_b[i]);
            end
            $display("bounce[%0d]: key=%b pressed=%b busy=%b", i, key, pressed, busy);
        end
    endtask

    // Reset while counting (cnt=2), key still high through deassertion.
    task automatic test_reset_mid_qual();
        bit exp_p[7] = '{0, 0, 0, 0, 0, 1, 1};
        bit exp_b[7] = '{0, 0, 1, 1, 1, 0, 0};
        key = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (busy !== 1'b1 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL midqual_busy: pressed=%b busy=%b, expected pressed=0 busy=1", pressed, busy);
        end
        $display("midqual_busy: pressed=%b busy=%b", pressed, busy);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL midqual_async_reset: pressed=%b busy=%b, expected pressed=0 busy=0", pressed, busy);
        end
        $display("midqual_async_reset: pressed=%b busy=%b", pressed, busy);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            vectors++;
            if (pressed !== exp_p[i] || busy !== exp_b[i]) begin
                errors++;
                $display("FAIL post_reset_press[%0d]: pressed=%b busy=%b, expected pressed=%b busy=%b",
                         i, pressed, busy, exp_p[i], exp_b[i]);
            end
            $display("post_reset_press[%0d]: key=%b pressed=%b busy=%b", i, key, pressed, busy);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b0;
        key     = 1'b0;
        test_reset();
        test_clean_press();
        test_hold();
        test_glitch_held();
        test_clean_release();
        test_bounce();
        test_clean_release();
        for (int i = 0; i < 3; i++) tick();
        test_reset_mid_qual();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw, asynchronous, possibly bouncing push-button into a clean, glitch-free `pressed` level. It sits upstream of the edge detector in the user-input path: switch pin → `button_debouncer` → edge detector → game logic. The block synchronizes the input with a two-flop chain and accepts a level change only after it has been stable for a programmable number of clock cycles.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronized cycles a new level must hold before `pressed` follows it. Legal range is ≥ 1. Use 4 for simulation and the equivalent of ~10 ms at board clock for hardware.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state immediately.
- `key` input, 1 bit: raw button level; asynchronous to `clk`; 1 = depressed.
- `pressed` output, 1 bit: debounced level, registered; 1 = button held.
- `busy` output, 1 bit: registered; 1 while a candidate level change is being qualified (counter nonzero).

## Operation
- Synchronizer: `sync1 <= key; sync2 <= sync1;`. Only `sync2` feeds the logic.
- Counter `cnt` is `$clog2(STABLE_CYCLES+1)` bits wide, unsigned, and saturates by construction (it never exceeds `STABLE_CYCLES-1`).
- State machine (`pressed` is the state bit; `busy` = `cnt != 0`):
  - RELEASED: `pressed`=0, `cnt`=0. If `sync2`=1, go to PRESS_WAIT with `cnt`=1, or go directly to PRESSED if `STABLE_CYCLES`=1.
  - PRESS_WAIT: `pressed`=0. If `sync2`=0, go to RELEASED with `cnt`=0. Else if `cnt`==`STABLE_CYCLES`-1, go to PRESSED with `cnt`=0. Else increment `cnt`.
  - PRESSED: `pressed`=1, `cnt`=0. If `sync2`=0, go to RELEASE_WAIT with `cnt`=1, or directly to RELEASED if `STABLE_CYCLES`=1.
  - RELEASE_WAIT: mirror of PRESS_WAIT. A `sync2`=1 sample returns to PRESSED with `cnt`=0. Reaching `STABLE_CYCLES` mismatching samples goes to RELEASED.
- Any sample that matches the current `pressed` level aborts qualification and clears `cnt`. Partial counts never carry over.
- `pressed` is glitch-free: it changes at most once per qualified transition and never pulses for less than `STABLE_CYCLES` cycles.

## Timing
- Reset values: `sync1`=0, `sync2`=0, `cnt`=0, `pressed`=0, `busy`=0, state RELEASED. All take effect asynchronously on `reset` assertion, including mid-qualification.
- Latency: if `key` settles before rising edge k, `sync2` reflects it after edge k+1. `pressed` changes after edge k+1+`STABLE_CYCLES`, a total of `STABLE_CYCLES`+2 edges (6 for the default).
- `busy` rises after edge k+2 and falls on the same edge that `pressed` changes, or on the abort edge.
- A bounce whose synchronized width is shorter than `STABLE_CYCLES` cycles produces no change on `pressed`.
- `key` held high through reset deassertion is treated as a new press: `pressed` rises `STABLE_CYCLES`+2 edges after the first post-reset edge.
- `pressed` feeds the edge detector directly; the edge detector sees exactly one rising edge per qualified press.

## Test plan
- Reset: assert `reset` with `key`=1 → `pressed`=0 and `busy`=0 immediately, before any clock edge. Hold for 3 edges → outputs stay 0.
- Clean press (`STABLE_CYCLES`=4): `key` 0→1 before edge 0 → `busy`=1 after edge 2; `pressed`=1 after edge 5; `busy`=0 on that same edge.
- Bounce rejection: `key` toggles 1,0,1,0,1 for 1 cycle each, then holds 1 → `pressed` stays 0 through the bounce. `pressed`=1 exactly 6 edges after the final 0→1.
- Short glitch while held: `pressed`=1, `key` drops to 0 for 3 cycles → `pressed` stays 1; `busy` pulses high then clears.
- Clean release: `key` 1→0 held → `pressed`=0 six edges later.
- Reset mid-qualification: assert `reset` while `cnt`=2 in PRESS_WAIT → `cnt`, `busy`, and `pressed` clear asynchronously. After release with `key`=1, `pressed` rises 6 edges later.
